stream_fifo: RTL and testbench

Parametrised ready/valid byte-stream FIFO placed between the usb_uart output stream and input stream (loopback, or any producer/consumer pair on clk_48mhz). It generalises the fixed 4-byte loopback buffer to configurable width and depth. It adds a registered output stage, occupancy and almost-full status, a synchronous flush, and an optional drop-on-full mode for producers that cannot be back-pressured.

---
 rtl/stream_fifo_pkg.sv | 29 ++
 rtl/stream_fifo_ram.sv | 28 ++
 rtl/stream_fifo.sv | 92 +++++++++
 tb/tb_stream_fifo.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/stream_fifo_pkg.sv
// rtl/stream_fifo_pkg.sv - shared widths, defaults and clog2 helper for stream_fifo
package stream_fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

  function automatic int addr_w(input int depth);
    return (depth <= 2) ? 1 : clog2(depth);
  endfunction

  // Pointers carry one extra wrap bit; level must reach DEPTH+1 (RAM plus output register).
  function automatic int ptr_w(input int depth);
    return addr_w(depth) + 1;
  endfunction

  function automatic int lvl_w(input int depth);
    return addr_w(depth) + 2;
  endfunction

endpackage

// File: rtl/stream_fifo_ram.sv
// rtl/stream_fifo_ram.sv - simple dual-port RAM, synchronous read, no reset on the array
module stream_fifo_ram #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk_48mhz,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [DATA_W-1:0] rd_data
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk_48mhz) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  // Only the read register is reset, so the head word reads as zero after reset.
  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/stream_fifo.sv
// rtl/stream_fifo.sv - ready/valid FIFO with registered output stage; STREAM_FIFO_STATS_EN adds drop_count
module stream_fifo
  import stream_fifo_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int DEPTH        = DEF_DEPTH,
  parameter int AFULL_LEVEL  = DEPTH - 4,
  parameter int DROP_ON_FULL = 0
) (
  input  logic                      clk_48mhz,
  input  logic                      reset,
  input  logic                      flush,
  input  logic [DATA_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  output logic [DATA_W-1:0]         out_data,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [lvl_w(DEPTH)-1:0]   level,
  output logic                      empty,
  output logic                      full,
  output logic                      almost_full
`ifdef STREAM_FIFO_STATS_EN
  ,
  output logic [15:0]               drop_count
`endif
);

  localparam int ADDR_W = addr_w(DEPTH);
  localparam int PTR_W  = ptr_w(DEPTH);
  localparam int LVL_W  = lvl_w(DEPTH);

  logic [PTR_W-1:0] wr_ptr, rd_ptr, ram_count;
  logic             ram_empty, wr_en, ld_en;

  assign ram_empty = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                     (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
  assign in_ready  = (DROP_ON_FULL != 0) ? 1'b1 : ~full;
  assign wr_en     = in_valid && in_ready && !full && !flush;
  assign ld_en     = !ram_empty && (!out_valid || out_ready) && !flush;

  assign ram_count   = wr_ptr - rd_ptr;
  assign level       = LVL_W'(ram_count) + LVL_W'(out_valid);
  assign empty       = (level == '0);
  assign almost_full = ({{(32-LVL_W){1'b0}}, level} >= 32'(AFULL_LEVEL));

  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      out_valid <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_W'(1);
      if (ld_en) begin
        rd_ptr    <= rd_ptr + PTR_W'(1);
        out_valid <= 1'b1;
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

  stream_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_48mhz (clk_48mhz),
    .reset     (reset),
    .wr_en     (wr_en),
    .wr_addr   (wr_ptr[ADDR_W-1:0]),
    .wr_data   (in_data),
    .rd_en     (ld_en),
    .rd_addr   (rd_ptr[ADDR_W-1:0]),
    .rd_data   (out_data)
  );

`ifdef STREAM_FIFO_STATS_EN
  always_ff @(posedge clk_48mhz or negedge reset) begin
    if (!reset) begin
      drop_count <= 16'd0;
    end else if (in_valid && full && (DROP_ON_FULL != 0) && (drop_count != 16'hFFFF)) begin
      drop_count <= drop_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// tb/tb_stream_fifo.sv - scoreboard bench for stream_fifo (back-pressure and drop-on-full instances)
module tb_stream_fifo;

  logic       clk_48mhz = 1'b0;
  logic       rst_n;
  always #5 clk_48mhz = ~clk_48mhz;

  logic       bp_flush, bp_in_valid, bp_in_ready, bp_out_valid, bp_out_ready;
  logic       bp_empty, bp_full, bp_afull;
  logic [7:0] bp_in_data, bp_out_data;
  logic [3:0] bp_level;
  logic       dr_flush, dr_in_valid, dr_in_ready, dr_out_valid, dr_out_ready;
  logic       dr_empty, dr_full, dr_afull;
  logic [7:0] dr_in_data, dr_out_data;
  logic [3:0] dr_level;
`ifdef STREAM_FIFO_STATS_EN
  logic [15:0] bp_drop, dr_drop;
`endif

  stream_fifo #(.DATA_W(8), .DEPTH(4), .AFULL_LEVEL(3), .DROP_ON_FULL(0)) u_bp (
    .clk_48mhz(clk_48mhz), .reset(rst_n), .flush(bp_flush),
    .in_data(bp_in_data), .in_valid(bp_in_valid), .in_ready(bp_in_ready),
    .out_data(bp_out_data), .out_valid(bp_out_valid), .out_ready(bp_out_ready),
    .level(bp_level), .empty(bp_empty), .full(bp_full), .almost_full(bp_afull)
`ifdef STREAM_FIFO_STATS_EN
    , .drop_count(bp_drop)
`endif
  );

  stream_fifo #(.DATA_W(8), .DEPTH(4), .AFULL_LEVEL(3), .DROP_ON_FULL(1)) u_dr (
    .clk_48mhz(clk_48mhz), .reset(rst_n), .flush(dr_flush),
    .in_data(dr_in_data), .in_valid(dr_in_valid), .in_ready(dr_in_ready),
    .out_data(dr_out_data), .out_valid(dr_out_valid), .out_ready(dr_out_ready),
    .level(dr_level), .empty(dr_empty), .full(dr_full), .almost_full(dr_afull)
`ifdef STREAM_FIFO_STATS_EN
    , .drop_count(dr_drop)
`endif
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [7:0] q_bp[$];
  logic [7:0] q_dr[$];
  int dr_words = 0;
  int bp_pops  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called just after a falling edge with inputs driven: record what the next rising edge does.
  task automatic step();
    logic [7:0] e;
    if (bp_in_valid && bp_in_ready && !bp_flush) q_bp.push_back(bp_in_data);
    if (bp_out_valid && bp_out_ready) begin
      bp_pops++;
      if (q_bp.size() == 0) check("bp_unexpected_word", {24'd0, bp_out_data}, 32'hFFFF_FFFF);
      else begin
        e = q_bp.pop_front();
        check("bp_data", {24'd0, bp_out_data}, {24'd0, e});
      end
    end
    if (dr_in_valid && dr_words < 5) begin
      q_dr.push_back(dr_in_data);
      dr_words++;
    end
    if (dr_out_valid && dr_out_ready) begin
      dr_words--;
      if (q_dr.size() == 0) check("dr_unexpected_word", {24'd0, dr_out_data}, 32'hFFFF_FFFF);
      else begin
        e = q_dr.pop_front();
        check("dr_data", {24'd0, dr_out_data}, {24'd0, e});
      end
    end
    @(posedge clk_48mhz);
    @(negedge clk_48mhz);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    int acc, sent, pops0;
    rst_n = 1'b0;
    bp_flush = 0; bp_in_valid = 0; bp_in_data = 0; bp_out_ready = 0;
    dr_flush = 0; dr_in_valid = 0; dr_in_data = 0; dr_out_ready = 0;
    repeat (3) @(negedge clk_48mhz);
    rst_n = 1'b1;
    @(negedge clk_48mhz);

    check("rst_level", 32'(bp_level), 32'd0);
    check("rst_empty", 32'(bp_empty), 32'd1);
    check("rst_full", 32'(bp_full), 32'd0);
    check("rst_afull", 32'(bp_afull), 32'd0);
    check("rst_in_ready", 32'(bp_in_ready), 32'd1);
    check("rst_out_valid", 32'(bp_out_valid), 32'd0);
    check("rst_out_data", 32'(bp_out_data), 32'd0);

    // Three words with the consumer always ready; first word appears two edges after accept.
    bp_out_ready = 1; bp_in_valid = 1; bp_in_data = 8'h41;
    step();
    check("lat_bubble", 32'(bp_out_valid), 32'd0);
    bp_in_data = 8'h42;
    step();
    check("lat_first_valid", 32'(bp_out_valid), 32'd1);
    check("lat_first_data", 32'(bp_out_data), 32'h41);
    bp_in_data = 8'h43;
    step();
    check("stream_consecutive", 32'(bp_out_valid), 32'd1);
    bp_in_valid = 0;
    idle(4);
    check("a_level", 32'(bp_level), 32'd0);
    check("a_empty", 32'(bp_empty), 32'd1);
    check("a_drained", 32'(q_bp.size()), 32'd0);

    // Back-pressure: six offered, five fit (4 RAM + output register).
    bp_out_ready = 0; acc = 0;
    for (int i = 0; i < 6; i++) begin
      bp_in_valid = 1; bp_in_data = 8'(8'h10 + i);
      if (bp_in_ready) acc++;
      step();
      check("b_level", 32'(bp_level), 32'(acc));
      check("b_afull", 32'(bp_afull), 32'(acc >= 3));
    end
    bp_in_valid = 0;
    check("b_accepted", 32'(acc), 32'd5);
    check("b_in_ready", 32'(bp_in_ready), 32'd0);
    check("b_full", 32'(bp_full), 32'd1);
    check("b_level5", 32'(bp_level), 32'd5);
    bp_out_ready = 1;
    idle(8);
    check("b_drained", 32'(q_bp.size()), 32'd0);
    check("b_empty", 32'(bp_empty), 32'd1);

    // Random valid/ready, 100 words, pointers wrap many times.
    sent = 0; pops0 = bp_pops;
    for (int c = 0; c < 3000; c++) begin
      if (sent == 100 && q_bp.size() == 0 && !bp_out_valid) break;
      bp_in_valid  = (sent < 100) && ($urandom_range(0, 3) != 0);
      bp_in_data   = 8'(sent);
      bp_out_ready = 1'($urandom_range(0, 1));
      if (bp_in_valid && bp_in_ready) sent++;
      step();
    end
    bp_in_valid = 0;
    check("rand_sent", 32'(sent), 32'd100);
    check("rand_popped", 32'(bp_pops - pops0), 32'd100);
    check("rand_left", 32'(q_bp.size()), 32'd0);

    // Drop-on-full: eight offered with consumer stalled, first five kept.
    dr_out_ready = 0;
    for (int i = 0; i < 8; i++) begin
      dr_in_valid = 1; dr_in_data = 8'(8'h60 + i);
      check("d_in_ready", 32'(dr_in_ready), 32'd1);
      step();
    end
    dr_in_valid = 0;
    check("d_level", 32'(dr_level), 32'd5);
    check("d_full", 32'(dr_full), 32'd1);
`ifdef STREAM_FIFO_STATS_EN
    check("d_drop_count", 32'(dr_drop), 32'd3);
    check("bp_drop_count", 32'(bp_drop), 32'd0);
`endif
    dr_out_ready = 1;
    idle(8);
    check("d_drained", 32'(q_dr.size()), 32'd0);
    check("d_empty", 32'(dr_empty), 32'd1);

    // Flush with a concurrent write: nothing survives, concurrent word is not stored.
    bp_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bp_in_valid = 1; bp_in_data = 8'(8'h20 + i);
      step();
    end
    bp_flush = 1; bp_in_data = 8'h99;
    step();
    bp_flush = 0; bp_in_valid = 0;
    q_bp.delete();
    check("f_level", 32'(bp_level), 32'd0);
    check("f_out_valid", 32'(bp_out_valid), 32'd0);
    check("f_empty", 32'(bp_empty), 32'd1);
    bp_out_ready = 1; bp_in_valid = 1; bp_in_data = 8'h55;
    step();
    bp_in_valid = 0;
    idle(4);
    check("f_after", 32'(q_bp.size()), 32'd0);

    // Asynchronous reset in the middle of a cycle with three words held.
    bp_out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      bp_in_valid = 1; bp_in_data = 8'(8'h30 + i);
      step();
    end
    bp_in_valid = 0;
    check("r_level_pre", 32'(bp_level), 32'd3);
    #2 rst_n = 1'b0;
    #1;
    check("r_level", 32'(bp_level), 32'd0);
    check("r_out_valid", 32'(bp_out_valid), 32'd0);
    check("r_out_data", 32'(bp_out_data), 32'd0);
    q_bp.delete(); q_dr.delete(); dr_words = 0;
    @(negedge clk_48mhz);
    rst_n = 1'b1;
    @(negedge clk_48mhz);
    bp_out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      bp_in_valid = 1; bp_in_data = 8'(8'hA0 + i);
      step();
    end
    bp_in_valid = 0;
    idle(5);
    check("r_resume", 32'(q_bp.size()), 32'd0);
    check("r_empty", 32'(bp_empty), 32'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
